// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Shared-register write arbiter. Several requesters compete to write one
// WIDTH-bit register. In IDLE the grant rotates round-robin, starting one
// past the last winner. A winner that also raises req_lock keeps exclusive
// ownership (LOCKED) until it drops req_lock or has held the lock for
// LOCK_MAX cycles. A forced release bars that requester from re-locking on
// its next IDLE grant, so it cannot hog the register indefinitely.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester write request
//   req_lock   per-requester request to keep ownership after the grant
//   req_data   packed write data, slice [i*WIDTH +: WIDTH] belongs to requester i
//   req_ready  one-hot (or zero) combinational grant; data is written this edge
//   reg_q      shared register contents
//   reg_owner  index of the requester that performed the last write
//   reg_upd    one-cycle pulse after every write
module reg_write_arbiter #(
    parameter int                 WIDTH     = 8,
    parameter int                 NUM_REQ   = 4,
    parameter int                 LOCK_MAX  = 15,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           reg_q,
    output logic [IW-1:0]              reg_owner,
    output logic                       reg_upd
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        last_grant_q, last_grant_d;
    logic [7:0]           lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0]   forced_q, forced_d;
    logic [WIDTH-1:0]     reg_d;
    logic [IW-1:0]        reg_owner_d;
    logic                 reg_upd_d;

    logic [IW-1:0]        winner;
    logic                 found;
    int                   cand;

    // The lock owner is always the last grantee: LOCKED is entered from an
    // IDLE grant and only the owner is eligible while locked, so last_grant
    // doubles as lock_owner and already holds the right value on exit.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_cnt_d   = lock_cnt_q;
        forced_d     = forced_q;
        reg_d        = reg_q;
        reg_owner_d  = reg_owner;
        reg_upd_d    = 1'b0;
        req_ready    = '0;
        winner       = last_grant_q;
        found        = 1'b0;
        cand         = 0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        cand = int'(last_grant_q) + k;
                        if (cand >= NUM_REQ) begin
                            cand = cand - NUM_REQ;
                        end
                        if (!found && req_valid[cand]) begin
                            found  = 1'b1;
                            winner = IW'(cand);
                        end
                    end
                    if (found) begin
                        req_ready[winner] = 1'b1;
                        reg_d             = req_data[int'(winner)*WIDTH +: WIDTH];
                        reg_owner_d       = winner;
                        reg_upd_d         = 1'b1;
                        last_grant_d      = winner;
                        // A grant after a forced release clears the bar but
                        // must not itself start a new lock.
                        if (forced_q[winner]) begin
                            forced_d[winner] = 1'b0;
                        end else if (req_lock[winner]) begin
                            state_d    = LOCKED;
                            lock_cnt_d = 8'd0;
                        end
                    end
                end

                LOCKED: begin
                    if (req_valid[last_grant_q]) begin
                        req_ready[last_grant_q] = 1'b1;
                        reg_d       = req_data[int'(last_grant_q)*WIDTH +: WIDTH];
                        reg_owner_d = last_grant_q;
                        reg_upd_d   = 1'b1;
                    end
                    lock_cnt_d = lock_cnt_q + 8'd1;
                    if (!req_lock[last_grant_q]) begin
                        state_d    = IDLE;
                        lock_cnt_d = 8'd0;
                    end else if (lock_cnt_q == 8'(LOCK_MAX - 1)) begin
                        state_d                = IDLE;
                        lock_cnt_d             = 8'd0;
                        forced_d[last_grant_q] = 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            lock_cnt_q   <= 8'd0;
            forced_q     <= '0;
            reg_q        <= RESET_VAL;
            reg_owner    <= '0;
            reg_upd      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            forced_q     <= forced_d;
            reg_q        <= reg_d;
            reg_owner    <= reg_owner_d;
            reg_upd      <= reg_upd_d;
        end
    end

endmodule
